// File: rtl/MIPS_pkg.sv
`default_nettype none
// ============================================================================
// MIPS_pkg: shared encodings for the multicycle MIPS control unit.
// Revision: 1.0
// ============================================================================
package MIPS_pkg;

  typedef enum logic [5:0] {
    OP_R    = 6'b000000,
    OP_J    = 6'b000010,
    OP_BEQ  = 6'b000100,
    OP_ADDI = 6'b001000,
    OP_LW   = 6'b100011,
    OP_SW   = 6'b101011
  } mips_op_e;

  typedef enum logic [5:0] {
    F_ADD = 6'b100000,
    F_SUB = 6'b100010,
    F_AND = 6'b100100,
    F_OR  = 6'b100101,
    F_SLT = 6'b101010
  } mips_funct_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// ============================================================================
// mips_alu_decoder: R-type funct field to ALU operation, with a legality flag.
// Revision: 1.0
// ============================================================================
module mips_alu_decoder
  import MIPS_pkg::*;
(
  input  logic [5:0] i_funct,
  output alu_ctrl_e  o_alu_ctrl,
  output logic       o_valid
);

  always_comb begin
    o_alu_ctrl = ALU_AND;
    o_valid    = 1'b1;
    case (i_funct)
      F_ADD:   o_alu_ctrl = ALU_ADD;
      F_SUB:   o_alu_ctrl = ALU_SUB;
      F_AND:   o_alu_ctrl = ALU_AND;
      F_OR:    o_alu_ctrl = ALU_OR;
      F_SLT:   o_alu_ctrl = ALU_SLT;
      default: o_valid    = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_control_fsm.sv
`default_nettype none
// ============================================================================
// mips_control_fsm: multicycle MIPS control unit with retire counter and
// memory-wait watchdog.  Revision: 1.0
// ============================================================================
module mips_control_fsm
  import MIPS_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_write,
  output logic                 iord,
  output logic                 alu_src_a,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic [2:0]           alu_ctrl,
  output logic                 illegal_instr,
  output logic                 mem_fault,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam int                   c_wait_w   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_wait_w-1:0]  c_wait_max = c_wait_w'(MEM_TIMEOUT);

  state_e                r_state, w_next;
  alu_ctrl_e             r_alu_ctrl, w_alu_ctrl, w_dec_ctrl;
  logic                  w_dec_valid;
  logic [c_wait_w-1:0]   r_wait_cnt, w_wait_next;
  logic [CNT_WIDTH-1:0]  r_retired;
  logic                  r_mem_fault;
  logic                  w_mem_req, w_pc_write, w_pc_write_cond, w_ir_write;
  logic                  w_reg_write, w_mem_write, w_illegal;
  logic                  w_waiting, w_retire;

  mips_alu_decoder u_alu_decoder (
    .i_funct    (funct),
    .o_alu_ctrl (w_dec_ctrl),
    .o_valid    (w_dec_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_alu_ctrl <= ALU_AND;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXEC) r_alu_ctrl <= w_dec_ctrl;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_mem_req       = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_mem_write     = 1'b0;
    w_illegal       = 1'b0;
    iord            = 1'b0;
    alu_src_a       = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    alu_src_b       = 2'b00;
    pc_src          = 2'b00;
    w_alu_ctrl      = ALU_AND;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alu_src_b  = 2'b01;
        w_alu_ctrl = ALU_ADD;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        w_alu_ctrl = ALU_ADD;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        w_alu_ctrl = ALU_ADD;
        w_next     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        iord      = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_req   = 1'b1;
        iord        = 1'b1;
        w_mem_write = mem_ready;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        w_alu_ctrl = w_dec_ctrl;
        if (w_dec_valid) begin
          w_next = S_ALUWB;
        end else begin
          w_next    = S_FETCH;
          w_illegal = 1'b1;
        end
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
        w_alu_ctrl  = r_alu_ctrl;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        w_alu_ctrl      = ALU_SUB;
        w_pc_write_cond = 1'b1;
        pc_src          = 2'b01;
        w_next          = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        w_alu_ctrl = ALU_ADD;
        w_next     = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write = 1'b1;
        pc_src     = 2'b10;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are gated by rst_n so they drop the instant reset asserts.
  assign mem_req       = rst_n & w_mem_req;
  assign pc_write      = rst_n & w_pc_write;
  assign pc_write_cond = rst_n & w_pc_write_cond;
  assign ir_write      = rst_n & w_ir_write;
  assign reg_write     = rst_n & w_reg_write;
  assign mem_write     = rst_n & w_mem_write;
  assign illegal_instr = rst_n & w_illegal;
  assign alu_ctrl      = w_alu_ctrl;

  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_MEMWB)  || (r_state == S_MEMWR) ||
                     (r_state == S_ALUWB)  || (r_state == S_BRANCH) ||
                     (r_state == S_ADDIWB) || (r_state == S_JUMP));

  assign w_waiting = w_mem_req & ~mem_ready;

  always_comb begin
    w_wait_next = '0;
    if (w_waiting) begin
      w_wait_next = (r_wait_cnt == c_wait_max) ? c_wait_max : r_wait_cnt + c_wait_w'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired   <= '0;
      r_wait_cnt  <= '0;
      r_mem_fault <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_next;
      if (w_retire) r_retired <= r_retired + CNT_WIDTH'(1);
      if (w_waiting && (w_wait_next == c_wait_max)) r_mem_fault <= 1'b1;
    end
  end

  assign retired   = r_retired;
  assign mem_fault = r_mem_fault;

endmodule
`default_nettype wire

// File: tb/tb_mips_control_fsm.sv
`default_nettype none
// ============================================================================
// tb_mips_control_fsm: directed + random instruction streams against a
// per-instruction step model.  Revision: 1.0
// ============================================================================
module tb_mips_control_fsm;

  localparam int CW = 4;
  localparam int TO = 15;

  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_SLT = 3'b111;

  typedef struct packed {
    logic       mem_req;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       iord;
    logic       alu_src_a;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
    logic       illegal;
  } ctl_t;

  // ctl: fixed outputs; rdy: bits that follow mem_ready; dc: unchecked bits
  typedef struct packed {
    ctl_t ctl;
    ctl_t rdy;
    ctl_t dc;
  } step_t;

  logic          clk, rst_n, mem_ready;
  logic [5:0]    op, funct;
  logic          mem_req, pc_write, pc_write_cond, ir_write, reg_write, mem_write;
  logic          iord, alu_src_a, reg_dst, mem_to_reg, illegal_instr, mem_fault;
  logic [1:0]    alu_src_b, pc_src;
  logic [2:0]    alu_ctrl;
  logic [CW-1:0] retired;

  int            checks = 0;
  int            errors = 0;
  int            run    = 0;
  logic          exp_fault;
  logic [CW-1:0] exp_retired;
  step_t         prog[$];
  logic          prog_legal;

  mips_control_fsm #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
    .iord(iord), .alu_src_a(alu_src_a), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctrl(alu_ctrl),
    .illegal_instr(illegal_instr), .mem_fault(mem_fault), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected step sequence of one instruction, straight from the control table.
  function automatic void build(input logic [5:0] op_v, input logic [5:0] funct_v);
    step_t      s;
    logic [2:0] ac;
    logic       fv;
    prog.delete();
    prog_legal = 1'b1;
    s = '0; s.ctl.mem_req = 1'b1; s.ctl.alu_src_b = 2'b01; s.ctl.alu_ctrl = A_ADD;
    s.rdy.ir_write = 1'b1; s.rdy.pc_write = 1'b1;
    prog.push_back(s);
    s = '0; s.ctl.alu_src_b = 2'b11; s.ctl.alu_ctrl = A_ADD;
    case (op_v)
      6'b100011, 6'b101011: begin
        prog.push_back(s);
        s = '0; s.ctl.alu_src_a = 1'b1; s.ctl.alu_src_b = 2'b10; s.ctl.alu_ctrl = A_ADD;
        prog.push_back(s);
        s = '0; s.ctl.mem_req = 1'b1; s.ctl.iord = 1'b1;
        if (op_v == 6'b100011) begin
          prog.push_back(s);
          s = '0; s.ctl.reg_write = 1'b1; s.ctl.mem_to_reg = 1'b1;
          prog.push_back(s);
        end else begin
          s.rdy.mem_write = 1'b1;
          prog.push_back(s);
        end
      end
      6'b000000: begin
        prog.push_back(s);
        fv = 1'b1;
        ac = A_AND;
        case (funct_v)
          6'b100000: ac = A_ADD;
          6'b100010: ac = A_SUB;
          6'b100100: ac = A_AND;
          6'b100101: ac = A_OR;
          6'b101010: ac = A_SLT;
          default:   fv = 1'b0;
        endcase
        s = '0; s.ctl.alu_src_a = 1'b1; s.ctl.alu_ctrl = ac;
        if (fv) begin
          prog.push_back(s);
          s = '0; s.ctl.reg_write = 1'b1; s.ctl.reg_dst = 1'b1; s.ctl.alu_ctrl = ac;
          prog.push_back(s);
        end else begin
          s.ctl.illegal = 1'b1; s.dc.alu_ctrl = '1;
          prog.push_back(s);
          prog_legal = 1'b0;
        end
      end
      6'b000100: begin
        prog.push_back(s);
        s = '0; s.ctl.alu_src_a = 1'b1; s.ctl.alu_ctrl = A_SUB;
        s.ctl.pc_write_cond = 1'b1; s.ctl.pc_src = 2'b01;
        prog.push_back(s);
      end
      6'b001000: begin
        prog.push_back(s);
        s = '0; s.ctl.alu_src_a = 1'b1; s.ctl.alu_src_b = 2'b10; s.ctl.alu_ctrl = A_ADD;
        prog.push_back(s);
        s = '0; s.ctl.reg_write = 1'b1;
        prog.push_back(s);
      end
      6'b000010: begin
        prog.push_back(s);
        s = '0; s.ctl.pc_write = 1'b1; s.ctl.pc_src = 2'b10;
        prog.push_back(s);
      end
      default: begin
        s.ctl.illegal = 1'b1;
        prog.push_back(s);
        prog_legal = 1'b0;
      end
    endcase
  endfunction

  task automatic drive_check(input step_t s, input logic rdy, input string tag);
    ctl_t exp, obs;
    mem_ready = rdy;
    #2;
    exp = s.ctl | (rdy ? s.rdy : '0);
    obs.mem_req = mem_req;         obs.pc_write = pc_write;
    obs.pc_write_cond = pc_write_cond; obs.ir_write = ir_write;
    obs.reg_write = reg_write;     obs.mem_write = mem_write;
    obs.iord = iord;               obs.alu_src_a = alu_src_a;
    obs.reg_dst = reg_dst;         obs.mem_to_reg = mem_to_reg;
    obs.alu_src_b = alu_src_b;     obs.pc_src = pc_src;
    obs.alu_ctrl = alu_ctrl;       obs.illegal = illegal_instr;
    chk({tag, ".ctl"}, 64'(obs & ~s.dc), 64'(exp & ~s.dc));
    chk({tag, ".retired"}, 64'(retired), 64'(exp_retired));
    chk({tag, ".fault"}, 64'(mem_fault), 64'(exp_fault));
  endtask

  task automatic end_cycle(input step_t s, input logic rdy);
    @(posedge clk);
    #1;
    if (s.ctl.mem_req && !rdy) begin
      run++;
      if (run >= TO) exp_fault = 1'b1;
    end else begin
      run = 0;
    end
  endtask

  task automatic run_instr(input logic [5:0] op_v, input logic [5:0] funct_v,
                           input int wf, input int wm, input string tag);
    logic rdy;
    int   n;
    op = op_v;
    funct = funct_v;
    build(op_v, funct_v);
    foreach (prog[i]) begin
      n = prog[i].ctl.mem_req ? ((i == 0) ? wf : wm) : 0;
      for (int w = 0; w <= n; w++) begin
        rdy = prog[i].ctl.mem_req ? (w == n) : 1'($urandom_range(0, 1));
        drive_check(prog[i], rdy, tag);
        end_cycle(prog[i], rdy);
      end
    end
    if (prog_legal) exp_retired = exp_retired + 1'b1;
  endtask

  // Asserts reset between edges, checks its immediate effect, releases after an edge.
  task automatic reset_mid(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ".strobes"}, 64'({mem_req, pc_write, pc_write_cond, ir_write,
                                reg_write, mem_write, illegal_instr}), 64'(0));
    chk({tag, ".retired"}, 64'(retired), 64'(0));
    chk({tag, ".fault"}, 64'(mem_fault), 64'(0));
    exp_retired = '0;
    exp_fault   = 1'b0;
    run         = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] rop, rfn;
    int         sel;
    rst_n = 1'b0; op = 6'b0; funct = 6'b0; mem_ready = 1'b1;
    exp_retired = '0; exp_fault = 1'b0;
    #3;
    reset_mid("por");

    run_instr(6'b100011, 6'b000000, 0, 0, "lw_ready");
    run_instr(6'b101011, 6'b000000, 0, 3, "sw_wait3");
    run_instr(6'b000000, 6'b100010, 0, 0, "r_sub");
    run_instr(6'b000000, 6'b111111, 1, 0, "r_badfunct");
    run_instr(6'b111111, 6'b000000, 0, 0, "bad_op");
    run_instr(6'b000100, 6'b000000, 2, 0, "beq");
    run_instr(6'b001000, 6'b000000, 0, 0, "addi");
    run_instr(6'b000010, 6'b000000, 0, 0, "j");

    for (int k = 0; k < 50; k++) begin
      sel = $urandom_range(0, 7);
      rfn = 6'($urandom_range(0, 63));
      case (sel)
        0: rop = 6'b100011;
        1: rop = 6'b101011;
        2: begin rop = 6'b000000; rfn = 6'b100000; end
        3: rop = 6'b000100;
        4: rop = 6'b001000;
        5: rop = 6'b000010;
        6: rop = 6'b000000;
        default: rop = 6'($urandom_range(0, 63));
      endcase
      run_instr(rop, rfn, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    run_instr(6'b000010, 6'b000000, 20, 0, "fault_fetch20");
    run_instr(6'b001000, 6'b000000, 0, 1, "fault_sticky");
    run_instr(6'b000000, 6'b101010, 0, 0, "fault_sticky2");
    reset_mid("fault_clear");
    run_instr(6'b000000, 6'b100101, 0, 0, "after_clear");

    // Reset while SW sits in the memory-write cycle with mem_ready high.
    op = 6'b101011;
    funct = 6'b000000;
    build(6'b101011, 6'b000000);
    for (int i = 0; i < 3; i++) begin
      drive_check(prog[i], 1'b1, "sw_rst");
      end_cycle(prog[i], 1'b1);
    end
    drive_check(prog[3], 1'b0, "sw_rst.wait");
    end_cycle(prog[3], 1'b0);
    drive_check(prog[3], 1'b1, "sw_rst.ready");
    reset_mid("sw_rst.reset");
    run_instr(6'b100011, 6'b000000, 0, 0, "lw_after_rst");
    run_instr(6'b000100, 6'b000000, 0, 0, "beq_last");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_control_fsm.md
MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, width of the retired-instruction counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, maximum mem_ready wait cycles before the fault flag is raised.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 op  input  6 (mips_op_e)  opcode field of the instruction register.
REQ-006 funct  input  6 (mips_funct_e)  funct field of the instruction register.
REQ-007 mem_ready  input  1  memory completes the current mem_req this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 pc_write, pc_write_cond, ir_write, reg_write, mem_write  output  1 each  datapath write strobes.
REQ-010 iord, alu_src_a, reg_dst, mem_to_reg  output  1 each  datapath mux selects.
REQ-011 alu_src_b, pc_src  output  2 each  datapath mux selects.
REQ-012 alu_ctrl  output  3  ALU operation: ADD=010, SUB=110, AND=000, OR=001, SLT=111.
REQ-013 illegal_instr  output  1  one-cycle pulse on an undecodable instruction.
REQ-014 mem_fault  output  1  sticky flag: a memory wait exceeded MEM_TIMEOUT.
REQ-015 retired  output  CNT_WIDTH  count of completed instructions.

Function
REQ-016 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-017 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00; ir_write=pc_write=mem_ready; go to DECODE when mem_ready=1, otherwise hold.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=ADD; by op: LW 100011 or SW 101011 -> MEMADR; R 000000 -> EXEC; BEQ 000100 -> BRANCH; ADDI 001000 -> ADDIEX; J 000010 -> JUMP; any other op -> FETCH with illegal_instr=1.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10, ADD; go to MEMRD for LW, MEMWR for SW.
REQ-020 MEMRD: mem_req=1, iord=1; go to MEMWB on mem_ready. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; go to FETCH.
REQ-021 MEMWR: mem_req=1, iord=1, mem_write=mem_ready; go to FETCH on mem_ready.
REQ-022 EXEC: alu_src_a=1, alu_src_b=00; funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT -> ALUWB; any other funct -> FETCH with illegal_instr=1, no register write.
REQ-023 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; alu_ctrl holds the EXEC decode.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_src=01. ADDIEX: alu_src_a=1, alu_src_b=10, ADD. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. JUMP: pc_write=1, pc_src=10.
REQ-025 Every state outputs 0 on any strobe or select not listed for it; outputs SHALL be combinational from state and the inputs named above.
REQ-026 retired SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP; it wraps from all-ones to 0; illegal instructions do not count.
REQ-027 A wait counter SHALL count consecutive cycles with mem_req=1 and mem_ready=0; when it reaches MEM_TIMEOUT, mem_fault is set and the FSM keeps waiting; the counter clears on mem_ready.
REQ-028 CPI SHALL be: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, each plus its mem_ready wait cycles.

Reset
REQ-029 rst_n=0 SHALL immediately force: state FETCH, retired 0, wait counter 0, mem_fault 0, illegal_instr 0, and mem_req and all write strobes 0, regardless of clk.
REQ-030 Reset deassertion mid-instruction SHALL resume at FETCH on the first clk edge with rst_n=1, with no partial write.

Structure
REQ-031 The opcode and funct enum literals, the alu_ctrl encoding typedef and the state enum SHALL go in MIPS_pkg.
REQ-032 The ALU-control decode (funct -> alu_ctrl) SHALL be a sub-module named mips_alu_decoder.

Verification
REQ-033 LW with mem_ready=1 always -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB in 5 cycles; reg_write=1 only in cycle 5; retired 0 -> 1.
REQ-034 SW with mem_ready low for 3 cycles in MEMWR -> mem_write=1 only in the ready cycle; total 7 cycles; no reg_write.
REQ-035 R-type SUB (funct 100010) -> alu_ctrl=110 in EXEC and ALUWB; funct 111111 -> illegal_instr pulse, back to FETCH, retired unchanged.
REQ-036 op 111111 -> illegal_instr=1 in DECODE, next state FETCH.
REQ-037 Hold mem_ready=0 in FETCH for 20 cycles -> mem_fault set at wait count 15 and stays set until rst_n=0.
REQ-038 Assert rst_n=0 in MEMWR between edges -> mem_req and mem_write drop immediately; after release the first state is FETCH.
